// File: rtl/puf_scan_unlock_seq.sv
// ---------------------------------------------------------------------------
// puf_scan_unlock_seq
//
// Purpose:
//   Runs an unlock sequence against an external ring-oscillator PUF core.
//   NUM_CHAL challenges (base, base+1, ... modulo 2^CHAL_W) go out one at a
//   time on a req/valid handshake. The responses are XOR-folded into a
//   target count, which is clamped up to MIN_COUNT. The block then counts
//   from 0 up to that target and raises scan_enable / count_done.
//   Each challenge has a response timeout. A timeout raises a sticky err
//   and parks the sequence in ERROR. abort returns the block to IDLE from
//   any state.
//
// Optional build macro:
//   PUF_SCAN_LOCKOUT_EN - adds a 2-bit saturating count of consecutive
//   ERROR entries. The third consecutive ERROR freezes the block: err stays
//   high, scan_enable stays low, and start/abort are ignored until rst_n.
//   This build adds the `locked` output.
//
// Ports:
//   clk            in   clock
//   rst_n          in   asynchronous active-low reset
//   start          in   one-cycle pulse; starts a sequence from IDLE/DONE/ERROR
//   abort          in   returns to IDLE from any state (highest priority)
//   base_challenge in   first challenge value (CHAL_W)
//   puf_req        out  one-cycle request to the PUF core
//   puf_challenge  out  challenge presented to the PUF (CHAL_W)
//   puf_response   in   PUF response (RESP_W)
//   puf_valid      in   response valid qualifier
//   target_count   out  folded and clamped target (CNT_W)
//   current_count  out  running counter (CNT_W)
//   scan_enable    out  scan unlock
//   count_done     out  sequence completed
//   busy           out  high while requesting, waiting, folding or counting
//   err            out  sticky timeout error
//   locked         out  (PUF_SCAN_LOCKOUT_EN only) permanent lockout
// ---------------------------------------------------------------------------
module puf_scan_unlock_seq #(
    parameter int RESP_W    = 16,
    parameter int CHAL_W    = 5,
    parameter int NUM_CHAL  = 4,
    parameter int CNT_W     = 16,
    parameter int MIN_COUNT = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CHAL_W-1:0] base_challenge,
    output logic              puf_req,
    output logic [CHAL_W-1:0] puf_challenge,
    input  logic [RESP_W-1:0] puf_response,
    input  logic              puf_valid,
    output logic [CNT_W-1:0]  target_count,
    output logic [CNT_W-1:0]  current_count,
    output logic              scan_enable,
    output logic              count_done,
    output logic              busy,
    output logic              err
`ifdef PUF_SCAN_LOCKOUT_EN
    ,
    output logic              locked
`endif
);

    // Index register is sized for the largest legal NUM_CHAL (16).
    localparam int IDX_W = 5;
    localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHAL - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] MIN_TGT  = CNT_W'(MIN_COUNT);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_FOLD  = 3'd3,
        ST_COUNT = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } state_t;

    // Low CNT_W bits of the folded accumulator, raised to at least MIN_COUNT.
    function automatic logic [CNT_W-1:0] clamp_target(input logic [RESP_W-1:0] acc);
        logic [CNT_W-1:0] t;
        t = acc[CNT_W-1:0];
        return (t < MIN_TGT) ? MIN_TGT : t;
    endfunction

    state_t              state_r;
    logic [RESP_W-1:0]   acc_r;
    logic [IDX_W-1:0]    idx_r;
    logic [TMR_W-1:0]    timer_r;
    logic [CHAL_W-1:0]   base_r;

    logic [CHAL_W-1:0]   next_chal_s;
    logic                last_chal_s;
    logic                timer_exp_s;
    logic                count_end_s;
    logic                hold_s;

    // Challenge for the next request; the add wraps modulo 2^CHAL_W.
    assign next_chal_s = base_r + CHAL_W'(idx_r) + CHAL_W'(1);
    assign last_chal_s = (idx_r == LAST_IDX);
    // Timer value seen on the last permitted WAIT cycle.
    assign timer_exp_s = (timer_r == TMR_LAST);
    assign count_end_s = (current_count == (target_count - CNT_W'(1)));

`ifdef PUF_SCAN_LOCKOUT_EN
    logic [1:0] err_streak_r;
    logic       locked_r;
    logic       err_entry_s;
    logic       done_entry_s;

    // The same conditions the FSM uses to enter ERROR and DONE.
    assign err_entry_s  = !hold_s && !abort && (state_r == ST_WAIT) &&
                          !puf_valid && timer_exp_s;
    assign done_entry_s = !hold_s && !abort && (state_r == ST_COUNT) && count_end_s;
    assign hold_s       = locked_r;
    assign locked       = locked_r;

    // Consecutive-error streak; the third ERROR entry in a row locks the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_streak_r <= 2'd0;
            locked_r     <= 1'b0;
        end else if (done_entry_s) begin
            err_streak_r <= 2'd0;
            locked_r     <= locked_r;
        end else if (err_entry_s) begin
            err_streak_r <= (err_streak_r == 2'd3) ? 2'd3 : err_streak_r + 2'd1;
            locked_r     <= locked_r | (err_streak_r == 2'd2);
        end else begin
            err_streak_r <= err_streak_r;
            locked_r     <= locked_r;
        end
    end
`else
    assign hold_s = 1'b0;
`endif

    // Main sequencer. All outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            acc_r         <= '0;
            idx_r         <= '0;
            timer_r       <= '0;
            base_r        <= '0;
            puf_req       <= 1'b0;
            puf_challenge <= '0;
            target_count  <= '0;
            current_count <= '0;
            scan_enable   <= 1'b0;
            count_done    <= 1'b0;
            busy          <= 1'b0;
            err           <= 1'b0;
        end else if (hold_s) begin
            // Locked out: frozen in ERROR until rst_n.
            state_r     <= ST_ERROR;
            puf_req     <= 1'b0;
            scan_enable <= 1'b0;
            count_done  <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b1;
        end else if (abort) begin
            // Abort beats start and puf_valid in the same cycle.
            state_r       <= ST_IDLE;
            acc_r         <= '0;
            idx_r         <= '0;
            timer_r       <= '0;
            puf_req       <= 1'b0;
            puf_challenge <= '0;
            target_count  <= '0;
            current_count <= '0;
            scan_enable   <= 1'b0;
            count_done    <= 1'b0;
            busy          <= 1'b0;
            err           <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        acc_r         <= '0;
                        idx_r         <= '0;
                        timer_r       <= '0;
                        base_r        <= base_challenge;
                        puf_challenge <= base_challenge;
                        puf_req       <= 1'b1;
                        current_count <= '0;
                        scan_enable   <= 1'b0;
                        count_done    <= 1'b0;
                        err           <= 1'b0;
                        busy          <= 1'b1;
                        state_r       <= ST_REQ;
                    end else begin
                        state_r <= state_r;
                    end
                end

                ST_REQ: begin
                    // The request is a single-cycle pulse. A valid seen
                    // here is ignored.
                    puf_req <= 1'b0;
                    timer_r <= '0;
                    state_r <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (puf_valid) begin
                        acc_r   <= acc_r ^ puf_response;
                        timer_r <= '0;
                        if (last_chal_s) begin
                            state_r <= ST_FOLD;
                        end else begin
                            idx_r         <= idx_r + IDX_W'(1);
                            puf_challenge <= next_chal_s;
                            puf_req       <= 1'b1;
                            state_r       <= ST_REQ;
                        end
                    end else if (timer_exp_s) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_ERROR;
                    end else begin
                        timer_r <= timer_r + TMR_W'(1);
                    end
                end

                ST_FOLD: begin
                    target_count  <= clamp_target(acc_r);
                    current_count <= '0;
                    state_r       <= ST_COUNT;
                end

                ST_COUNT: begin
                    // DONE is entered on the edge that makes current_count
                    // equal to the target, so COUNT lasts target_count cycles.
                    if (count_end_s) begin
                        current_count <= target_count;
                        scan_enable   <= 1'b1;
                        count_done    <= 1'b1;
                        busy          <= 1'b0;
                        state_r       <= ST_DONE;
                    end else begin
                        current_count <= current_count + CNT_W'(1);
                    end
                end

                default: begin
                    state_r     <= ST_IDLE;
                    puf_req     <= 1'b0;
                    scan_enable <= 1'b0;
                    count_done  <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_scan_unlock_seq.sv
// ---------------------------------------------------------------------------
// tb_puf_scan_unlock_seq
//
// Self-checking bench for puf_scan_unlock_seq. The bench acts as the PUF
// core. It replies to each request after a chosen delay, can withhold one
// reply to force a timeout, and can inject a bogus valid in the request
// cycle. Expected targets, challenge sequences and latencies come from the
// rules of the block: XOR fold, clamp, and request/wait/count cycle sums.
// ---------------------------------------------------------------------------
module tb_puf_scan_unlock_seq;

    localparam int RESP_W    = 16;
    localparam int CHAL_W    = 5;
    localparam int NUM_CHAL  = 4;
    localparam int CNT_W     = 16;
    localparam int MIN_COUNT = 16;
    localparam int TIMEOUT   = 255;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [CHAL_W-1:0] base_challenge;
    logic              puf_req;
    logic [CHAL_W-1:0] puf_challenge;
    logic [RESP_W-1:0] puf_response;
    logic              puf_valid;
    logic [CNT_W-1:0]  target_count;
    logic [CNT_W-1:0]  current_count;
    logic              scan_enable;
    logic              count_done;
    logic              busy;
    logic              err;
`ifdef PUF_SCAN_LOCKOUT_EN
    logic              locked;
`endif

    int checks = 0;
    int errors = 0;
    int resp_a [NUM_CHAL];

    always #5 clk = ~clk;

    puf_scan_unlock_seq #(
        .RESP_W(RESP_W), .CHAL_W(CHAL_W), .NUM_CHAL(NUM_CHAL),
        .CNT_W(CNT_W), .MIN_COUNT(MIN_COUNT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_challenge(base_challenge), .puf_req(puf_req),
        .puf_challenge(puf_challenge), .puf_response(puf_response),
        .puf_valid(puf_valid), .target_count(target_count),
        .current_count(current_count), .scan_enable(scan_enable),
        .count_done(count_done), .busy(busy), .err(err)
`ifdef PUF_SCAN_LOCKOUT_EN
        , .locked(locked)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: XOR of all responses, low CNT_W bits, raised to MIN_COUNT.
    function automatic int model_target();
        int acc = 0;
        int t;
        for (int i = 0; i < NUM_CHAL; i++) acc = acc ^ resp_a[i];
        t = acc % (1 << CNT_W);
        return (t < MIN_COUNT) ? MIN_COUNT : t;
    endfunction

    // drop: challenge index left unanswered (-1 none); abort_at: count value
    // at which abort is pulsed (-1 none).
    task automatic run_seq(input string name, input int base, input int drop,
                           input int abort_at, input bit rand_delay, input bit garbage);
        int cyc = 0, k = 0, pending = -1, dsum = 0, req_cyc = 0, d = 0;
        int exp_t, outcome = 0, exp_outcome;
        bit prev_req = 1'b0, aborted = 1'b0;
        exp_t = model_target();
        exp_outcome = (drop >= 0) ? 2 : ((abort_at >= 0) ? 3 : 1);
        base_challenge = base[CHAL_W-1:0];
        start = 1'b1;
        while (outcome == 0 && cyc < 3000) begin
            tick();
            cyc++;
            start = 1'b0;
            puf_valid = 1'b0;
            if (aborted) begin
                abort = 1'b0;
                checks++;
                if ({puf_req, puf_challenge, target_count, current_count,
                     scan_enable, count_done, busy, err} !== '0) begin
                    errors++;
                    $display("FAIL %s abort_clear: outputs=%h busy=%b required all zero", name,
                             {puf_req, puf_challenge, target_count, current_count,
                              scan_enable, count_done, err}, busy);
                end
                outcome = 3;
            end else begin
                if (cyc == 1) begin
                    checks++;
                    if (busy !== 1'b1 || err !== 1'b0) begin
                        errors++;
                        $display("FAIL %s start_state: busy=%b err=%b required busy=1 err=0", name, busy, err);
                    end
                end
                if (prev_req) begin
                    checks++;
                    if (puf_req !== 1'b0) begin
                        errors++;
                        $display("FAIL %s req_pulse: puf_req=%b required 0 after one cycle", name, puf_req);
                    end
                end
                prev_req = puf_req;
                if (puf_req) begin
                    checks++;
                    if (puf_challenge !== CHAL_W'((base + k) % (1 << CHAL_W))) begin
                        errors++;
                        $display("FAIL %s challenge[%0d]: got %0d required %0d", name, k,
                                 puf_challenge, (base + k) % (1 << CHAL_W));
                    end
                    k++;
                    req_cyc = cyc;
                    if (k - 1 == drop) begin
                        pending = -1;
                    end else begin
                        d = rand_delay ? int'($urandom_range(0, 3)) : 0;
                        dsum += d;
                        pending = 1 + d;
                    end
                    if (garbage) begin
                        puf_valid = 1'b1;
                        puf_response = RESP_W'($urandom);
                    end
                end else if (pending > 0) begin
                    pending--;
                    if (pending == 0) begin
                        puf_valid = 1'b1;
                        puf_response = RESP_W'(resp_a[k-1]);
                        pending = -1;
                    end
                end
                if (abort_at >= 0 && busy && current_count == CNT_W'(abort_at)) begin
                    abort = 1'b1;
                    aborted = 1'b1;
                end else if (count_done) begin
                    outcome = 1;
                end else if (err) begin
                    outcome = 2;
                end
            end
        end
        puf_valid = 1'b0;
        checks++;
        if (outcome !== exp_outcome) begin
            errors++;
            $display("FAIL %s outcome: got %0d required %0d after %0d cycles", name, outcome, exp_outcome, cyc);
        end
        if (exp_outcome == 1 && outcome == 1) begin
            checks++;
            if (cyc != 2 + 2 * NUM_CHAL + exp_t + dsum) begin
                errors++;
                $display("FAIL %s latency: got %0d required %0d", name, cyc, 2 + 2 * NUM_CHAL + exp_t + dsum);
            end
            checks++;
            if (target_count !== CNT_W'(exp_t) || k != NUM_CHAL) begin
                errors++;
                $display("FAIL %s target: got %0d (%0d reqs) required %0d (%0d reqs)", name,
                         target_count, k, exp_t, NUM_CHAL);
            end
            repeat (3) tick();
            checks++;
            if (current_count !== CNT_W'(exp_t) || scan_enable !== 1'b1 ||
                count_done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
                errors++;
                $display("FAIL %s done_hold: cc=%0d se=%b cd=%b busy=%b err=%b required cc=%0d se=1 cd=1 busy=0 err=0",
                         name, current_count, scan_enable, count_done, busy, err, exp_t);
            end
        end
        if (exp_outcome == 2 && outcome == 2) begin
            checks++;
            if (cyc - req_cyc != TIMEOUT + 1) begin
                errors++;
                $display("FAIL %s timeout_len: wait cycles %0d required %0d", name, cyc - req_cyc - 1, TIMEOUT);
            end
            checks++;
            if (scan_enable !== 1'b0 || busy !== 1'b0 || count_done !== 1'b0) begin
                errors++;
                $display("FAIL %s error_state: se=%b busy=%b cd=%b required 0 0 0", name, scan_enable, busy, count_done);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; puf_valid = 1'b0;
        puf_response = '0; base_challenge = '0;
        repeat (3) tick();
        checks++;
        if ({puf_req, puf_challenge, target_count, current_count,
             scan_enable, count_done, busy, err} !== '0) begin
            errors++;
            $display("FAIL reset_values: got %h required 0", {puf_req, puf_challenge, target_count,
                     current_count, scan_enable, count_done, busy, err});
        end
`ifdef PUF_SCAN_LOCKOUT_EN
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL reset_locked: got %b required 0", locked);
        end
`endif
        rst_n = 1'b1;
        repeat (2) tick();
        checks++;
        if (busy !== 1'b0 || puf_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b req=%b required 0 0", busy, puf_req);
        end
    endtask

    task automatic test_spec_vector();
        resp_a = '{32'h1234, 32'h00FF, 32'h1200, 32'h0001};
        run_seq("spec_vector", 0, -1, -1, 1'b0, 1'b0);
        checks++;
        if (target_count !== 16'd202) begin
            errors++;
            $display("FAIL spec_target: got %0d required 202", target_count);
        end
    endtask

    task automatic test_min_clamp();
        resp_a = '{32'h0005, 32'h0005, 32'h0005, 32'h0005};
        run_seq("min_clamp", 7, -1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        resp_a = '{32'h0040, 32'h0003, 32'h0100, 32'h0011};
        run_seq("wrap", 30, -1, -1, 1'b0, 1'b1);
    endtask

    task automatic test_timeout();
        resp_a = '{32'h0021, 32'h0002, 32'h0004, 32'h0008};
        run_seq("timeout", 3, 1, -1, 1'b0, 1'b0);
        run_seq("recover", 9, -1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_abort_count();
        resp_a = '{32'h0100, 32'h0000, 32'h0000, 32'h0000};
        run_seq("abort_count", 1, -1, 50, 1'b0, 1'b0);
    endtask

    task automatic test_abort_collide();
        resp_a = '{32'h0030, 32'h0000, 32'h0001, 32'h0000};
        run_seq("pre_collide", 4, -1, -1, 1'b0, 1'b0);
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        tick();
        checks++;
        if ({puf_req, target_count, current_count, scan_enable, count_done, busy, err} !== '0) begin
            errors++;
            $display("FAIL abort_with_start: got %h required 0",
                     {puf_req, target_count, current_count, scan_enable, count_done, busy, err});
        end
        // abort together with a valid response while waiting
        base_challenge = 5'd2; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        puf_valid = 1'b1; puf_response = 16'h00AA; abort = 1'b1;
        tick();
        puf_valid = 1'b0; abort = 1'b0;
        checks++;
        if ({puf_req, puf_challenge, busy, err} !== '0) begin
            errors++;
            $display("FAIL abort_with_valid: req=%b chal=%0d busy=%b err=%b required 0",
                     puf_req, puf_challenge, busy, err);
        end
    endtask

    task automatic test_reset_mid();
        for (int v = 0; v < 2; v++) begin
            base_challenge = 5'd12; start = 1'b1;
            tick();
            start = 1'b0;
            if (v == 1) tick();
            rst_n = 1'b0;
            #1;
            checks++;
            if (puf_req !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_%0d: req=%b busy=%b required 0 0", v, puf_req, busy);
            end
            #2;
            rst_n = 1'b1;
        end
        // late valid while idle is ignored
        puf_valid = 1'b1; puf_response = 16'h7777;
        repeat (2) tick();
        puf_valid = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || puf_req !== 1'b0 || target_count !== '0) begin
            errors++;
            $display("FAIL late_valid: busy=%b req=%b tgt=%0d required 0 0 0", busy, puf_req, target_count);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < NUM_CHAL; i++) resp_a[i] = int'($urandom_range(0, 511));
            run_seq("random", int'($urandom_range(0, 31)), -1, -1, 1'b1, 1'b1);
        end
    endtask

`ifdef PUF_SCAN_LOCKOUT_EN
    task automatic test_lockout();
        resp_a = '{32'h0021, 32'h0002, 32'h0004, 32'h0008};
        for (int n = 0; n < 3; n++) begin
            run_seq("lockout_timeout", n, 0, -1, 1'b0, 1'b0);
            checks++;
            if (locked !== (n == 2)) begin
                errors++;
                $display("FAIL lockout_%0d: locked=%b required %b", n, locked, (n == 2));
            end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || err !== 1'b1 || locked !== 1'b1 || scan_enable !== 1'b0 || puf_req !== 1'b0) begin
            errors++;
            $display("FAIL lockout_hold: busy=%b err=%b locked=%b se=%b req=%b required 0 1 1 0 0",
                     busy, err, locked, scan_enable, puf_req);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (locked !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL lockout_reset: locked=%b err=%b required 0 0", locked, err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_spec_vector();
        test_min_clamp();
        test_wrap();
        test_timeout();
        test_abort_count();
        test_abort_collide();
        test_reset_mid();
        test_random();
`ifdef PUF_SCAN_LOCKOUT_EN
        test_lockout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/puf_scan_unlock_seq.md
Name: puf_scan_unlock_seq

Overview:
- Parametrised successor to the single-shot PUF counter integration.
- Issues NUM_CHAL sequential challenges to an external RO-PUF core through a req/valid handshake.
- XOR-folds the responses into a target count, clamped to a minimum, then counts to that target and asserts scan_enable.
- Adds a per-challenge response timeout, abort, and a sticky error. Sits between the PUF core and the scan-chain enable logic.

Parameters:
- RESP_W, 16, PUF response width.
- CHAL_W, 5, challenge width.
- NUM_CHAL, 4, challenges per unlock sequence (1..16).
- CNT_W, 16, counter and target width (CNT_W <= RESP_W).
- MIN_COUNT, 16, minimum target after folding.
- TIMEOUT, 255, max cycles waiting for puf_valid per challenge.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse; starts a sequence when in IDLE, DONE or ERROR.
- abort, input, 1, returns to IDLE from any state.
- base_challenge, input, CHAL_W, first challenge value.
- puf_req, output, 1, one-cycle request to PUF core.
- puf_challenge, output, CHAL_W, challenge presented to PUF.
- puf_response, input, RESP_W, PUF response.
- puf_valid, input, 1, response valid qualifier.
- target_count, output, CNT_W, folded and clamped target.
- current_count, output, CNT_W, running counter.
- scan_enable, output, 1, scan unlock.
- count_done, output, 1, sequence completed.
- busy, output, 1, high in REQ/WAIT/FOLD/COUNT.
- err, output, 1, sticky timeout error.

Behaviour:
- Reset values: all outputs 0; state IDLE; accumulator, challenge index and timer cleared.
- FSM states: IDLE, REQ, WAIT, FOLD, COUNT, DONE, ERROR.
- IDLE/DONE/ERROR + start:
  - clears accumulator, index, current_count, scan_enable, count_done, err;
  - latches base_challenge;
  - next state REQ.
- REQ:
  - puf_req=1 for exactly one cycle;
  - puf_challenge = base + idx, modulo 2^CHAL_W, so it wraps (base 30, CHAL_W 5 gives 30,31,0,1);
  - clears the timeout timer; next state WAIT.
  - puf_challenge holds its value through WAIT.
- WAIT:
  - puf_valid high: acc <= acc ^ puf_response. If idx == NUM_CHAL-1 go to FOLD, else idx++ and go to REQ.
  - puf_valid in the same cycle as REQ is ignored.
  - Timer increments each WAIT cycle. When it reaches TIMEOUT without puf_valid: err=1, go to ERROR.
- FOLD (one cycle):
  - t = acc[CNT_W-1:0];
  - target_count <= (t < MIN_COUNT) ? MIN_COUNT : t;
  - next state COUNT.
- COUNT:
  - current_count increments by 1 per cycle starting from 0.
  - On the cycle current_count == target_count-1: current_count <= target_count, go to DONE.
  - scan_enable and count_done rise on the DONE-entry edge, so COUNT lasts target_count cycles.
- DONE:
  - scan_enable=1, count_done=1, target_count and current_count held;
  - stays until start (restart) or abort.
- ERROR: err=1, scan_enable=0; exits on start (restart) or abort (to IDLE, err cleared).
- abort: highest priority in every state; next state IDLE, all outputs cleared. This includes abort coinciding with start or puf_valid.
- Late puf_valid outside WAIT: ignored.
- Reset mid-sequence: immediate return to reset values with no pending request.
- Latency, start to count_done, with 1-cycle PUF replies: 1 + NUM_CHAL*2 + 1 + target_count cycles.

Optional Feature:
- Macro: PUF_SCAN_LOCKOUT_EN.
- Defined:
  - 2-bit saturating count of consecutive ERROR entries; a successful DONE clears it.
  - On the 3rd consecutive ERROR, the locked state is entered. start and abort are ignored, err stays 1 and scan_enable stays 0 until rst_n.
  - Adds output `locked` (1 bit, reset 0).
- Not defined: no lockout counter and no `locked` port; ERROR is always recoverable with start.

Test Plan:
- NUM_CHAL=4, base 0, responses 0x1234, 0x00FF, 0x1200, 0x0001 (1-cycle replies) -> challenges 0,1,2,3; target_count=0x00CA (202); scan_enable and count_done rise 212 cycles after start; current_count=202 is held.
- Responses 0x0005 x4 -> fold 0 -> target_count=16; scan_enable after 16 COUNT cycles.
- base_challenge=30 -> puf_challenge sequence 30,31,0,1; each puf_req is exactly one cycle.
- No puf_valid on the 2nd challenge -> err=1 after exactly 255 WAIT cycles, state ERROR, scan_enable=0; a start then completes normally and clears err.
- abort asserted mid-COUNT (current_count=50) -> next cycle all outputs 0, IDLE. rst_n low mid-WAIT -> puf_req=0, busy=0 immediately.
- PUF_SCAN_LOCKOUT_EN: three consecutive timeouts -> locked=1; a start is ignored; only rst_n clears locked.
